// File: rtl/cdb_arbiter_pkg.sv
// Shared CDB types: tagged result payload, bus format, FU indices and tag prefixes.
package cdb_arbiter_pkg;

  localparam int NUM_SRBITS = 5;
  localparam int FU_BITS    = 3;
  localparam int TAG_W      = FU_BITS + NUM_SRBITS;
  localparam int DATA_W     = 32;

  typedef logic [TAG_W-1:0]  tag_t;
  typedef logic [DATA_W-1:0] data_t;

  typedef struct packed {
    tag_t  tag;
    data_t data;
  } tagged_data_t;

  typedef struct packed {
    logic  valid;
    tag_t  tag;
    data_t data;
  } cdb_bus_t;

  localparam logic [FU_BITS-1:0] FU_TAG_ALU  = 3'd0;
  localparam logic [FU_BITS-1:0] FU_TAG_JUMP = 3'd1;
  localparam logic [FU_BITS-1:0] FU_TAG_LS   = 3'd2;
  localparam logic [FU_BITS-1:0] FU_TAG_MUL  = 3'd3;
  localparam logic [FU_BITS-1:0] FU_TAG_DIV  = 3'd4;

  localparam int NUM_REQ_DEF = 5;
  localparam int FU_IDX_ALU  = 0;
  localparam int FU_IDX_JUMP = 1;
  localparam int FU_IDX_LS   = 2;
  localparam int FU_IDX_MUL  = 3;
  localparam int FU_IDX_DIV  = 4;

endpackage

// File: rtl/cdb_arbiter_rr_pick.sv
// Rotate-priority picker: first set request at or after i_start (wrapping), one-hot out.
module rr_pick #(
  parameter int N     = 5,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_start,
  output logic [N-1:0]     o_gnt
);

  logic w_found;
  int   w_idx;

  always_comb begin
    o_gnt   = '0;
    w_found = 1'b0;
    w_idx   = 0;
    for (int k = 0; k < N; k++) begin
      w_idx = int'(i_start) + k;
      if (w_idx >= N) w_idx = w_idx - N;
      if (!w_found && i_req[w_idx]) begin
        o_gnt[w_idx] = 1'b1;
        w_found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: round-robin between FU result requests with starvation
// override; winner is broadcast on a registered CDB one cycle after arbitration.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_REQ      = NUM_REQ_DEF,
  parameter int STARVE_LIMIT = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic [NUM_REQ-1:0] req_i,
  input  tagged_data_t       data_i [NUM_REQ],
  output cdb_bus_t           cdb_o,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [NUM_REQ-1:0] stall_o
);

  localparam int         IDX_W     = $clog2(NUM_REQ);
  localparam logic [3:0] CNT_LIMIT = 4'(STARVE_LIMIT);

  cdb_bus_t           r_cdb;
  logic [NUM_REQ-1:0] r_gnt;
  logic [NUM_REQ-1:0] r_stall;
  logic [3:0]         r_cnt [NUM_REQ];
  logic [IDX_W-1:0]   r_start;

  logic [NUM_REQ-1:0] w_elig;
  logic [NUM_REQ-1:0] w_starved;
  logic [NUM_REQ-1:0] w_forced_gnt;
  logic [NUM_REQ-1:0] w_rr_gnt;
  logic [NUM_REQ-1:0] w_gnt;
  logic [IDX_W-1:0]   w_win_idx;
  tagged_data_t       w_win;

  // The FU granted last cycle still holds req while it retires it; keep it out.
  assign w_elig = req_i & ~r_gnt;

  always_comb begin
    w_starved = '0;
    for (int i = 0; i < NUM_REQ; i++)
      w_starved[i] = w_elig[i] && (r_cnt[i] == CNT_LIMIT);
  end

  assign w_forced_gnt = w_starved & (~w_starved + NUM_REQ'(1));

  rr_pick #(.N(NUM_REQ), .IDX_W(IDX_W)) u_pick (
    .i_req   (w_elig),
    .i_start (r_start),
    .o_gnt   (w_rr_gnt)
  );

  assign w_gnt = (|w_starved) ? w_forced_gnt : w_rr_gnt;

  always_comb begin
    w_win_idx = '0;
    w_win     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_gnt[i]) begin
        w_win_idx = IDX_W'(i);
        w_win     = data_i[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cdb   <= '0;
      r_gnt   <= '0;
      r_stall <= '0;
      r_start <= '0;
      for (int i = 0; i < NUM_REQ; i++) r_cnt[i] <= '0;
    end else if (flush) begin
      r_cdb.valid <= 1'b0;
      r_cdb.tag   <= '0;
      r_gnt       <= '0;
      r_stall     <= '0;
      for (int i = 0; i < NUM_REQ; i++) r_cnt[i] <= '0;
    end else begin
      r_gnt       <= w_gnt;
      r_stall     <= req_i & ~w_gnt;
      r_cdb.valid <= |w_gnt;
      if (|w_gnt) begin
        r_cdb.tag  <= w_win.tag;
        r_cdb.data <= w_win.data;
        r_start    <= (w_win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : w_win_idx + IDX_W'(1);
      end else begin
        r_cdb.tag <= '0;
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!req_i[i] || w_gnt[i])
          r_cnt[i] <= '0;
        else if (w_elig[i] && r_cnt[i] != CNT_LIMIT)
          r_cnt[i] <= r_cnt[i] + 4'd1;
      end
    end
  end

  assign cdb_o   = r_cdb;
  assign gnt_o   = r_gnt;
  assign stall_o = r_stall;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Randomized bench for cdb_arbiter against a cycle-level behavioural model,
// plus directed scenarios with hand-computed expectations.
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  localparam int N   = 5;
  localparam int LIM = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         flush;
  logic [N-1:0] req;
  tagged_data_t din [N];
  cdb_bus_t     cdb;
  logic [N-1:0] gnt;
  logic [N-1:0] stall;

  always #5 clk = ~clk;

  cdb_arbiter #(.NUM_REQ(N), .STARVE_LIMIT(LIM)) dut (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .req_i   (req),
    .data_i  (din),
    .cdb_o   (cdb),
    .gnt_o   (gnt),
    .stall_o (stall)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // model state
  bit           m_valid;
  tag_t         m_tag;
  data_t        m_data;
  int           m_win;
  int           m_start;
  int           m_cnt [N];
  logic [N-1:0] m_stall;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_tag   = '0;
    m_data  = '0;
    m_win   = -1;
    m_start = 0;
    m_stall = '0;
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
  endtask

  task automatic model_edge();
    bit elig [N];
    int w;
    int j;
    if (flush) begin
      m_valid = 1'b0;
      m_tag   = '0;
      m_win   = -1;
      m_stall = '0;
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
      return;
    end
    for (int i = 0; i < N; i++) elig[i] = req[i] && (i != m_win);
    w = -1;
    for (int i = 0; i < N; i++)
      if (w < 0 && elig[i] && m_cnt[i] == LIM) w = i;
    if (w < 0)
      for (int k = 0; k < N; k++) begin
        j = (m_start + k) % N;
        if (w < 0 && elig[j]) w = j;
      end
    for (int i = 0; i < N; i++) begin
      if (!req[i] || i == w) m_cnt[i] = 0;
      else if (elig[i] && m_cnt[i] < LIM) m_cnt[i]++;
    end
    m_stall = req;
    if (w >= 0) begin
      m_stall[w] = 1'b0;
      m_valid    = 1'b1;
      m_tag      = din[w].tag;
      m_data     = din[w].data;
      m_start    = (w + 1) % N;
    end else begin
      m_valid = 1'b0;
      m_tag   = '0;
    end
    m_win = w;
  endtask

  task automatic compare_outputs();
    logic [N-1:0] eg;
    eg = '0;
    if (m_win >= 0) eg[m_win] = 1'b1;
    check("cdb_valid", 64'(cdb.valid), 64'(m_valid));
    check("cdb_tag",   64'(cdb.tag),   64'(m_tag));
    check("cdb_data",  64'(cdb.data),  64'(m_data));
    check("gnt",       64'(gnt),       64'(eg));
    check("stall",     64'(stall),     64'(m_stall));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    compare_outputs();
  endtask

  task automatic set_fu(input int i, input logic [7:0] tag, input logic [31:0] data);
    din[i].tag  = tag;
    din[i].data = data;
  endtask

  logic [N-1:0] exp_v;
  bit           seen;

  initial begin
    rst   = 1'b1;
    flush = 1'b0;
    req   = '0;
    for (int i = 0; i < N; i++) set_fu(i, 8'(i << 5), 32'h100 + 32'(i));
    model_reset();
    #1;
    check("reset_cdb",   64'(cdb),   64'd0);
    check("reset_gnt",   64'(gnt),   64'd0);
    check("reset_stall", 64'(stall), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // single DIV request, held one extra cycle
    set_fu(4, 8'h84, 32'h0000_0007);
    req = 5'b10000;
    tick();
    check("single_cdb", 64'(cdb), {23'd0, 1'b1, 8'h84, 32'h7});
    check("single_gnt", 64'(gnt), 64'h10);
    @(negedge clk);
    tick();
    check("held_no_regrant", 64'(gnt), 64'h0);
    check("held_stall", 64'(stall), 64'h10);
    @(negedge clk);
    req = '0;
    tick();

    // all five requesting, each drops after its grant
    @(negedge clk);
    for (int i = 0; i < N; i++) set_fu(i, {3'(i), 5'(i + 1)}, 32'hA000 + 32'(i));
    req = 5'b11111;
    for (int k = 0; k < N; k++) begin
      tick();
      exp_v = '0;
      exp_v[k] = 1'b1;
      check("all5_gnt", 64'(gnt), 64'(exp_v));
      exp_v = 5'(5'h1f << (k + 1));
      check("all5_stall", 64'(stall), 64'(exp_v));
      @(negedge clk);
      req = req & ~gnt;
    end
    tick();

    // FU3 waiting behind FU0/FU1
    @(negedge clk);
    req  = 5'b01011;
    seen = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (!seen) begin
        tick();
        if (gnt[3]) seen = 1'b1;
        @(negedge clk);
      end
    end
    check("starve_fu3_within_3", 64'(seen), 64'd1);
    req = '0;
    tick();

    // flush with three pending; pointer now starts at 4
    @(negedge clk);
    req   = 5'b10110;
    flush = 1'b1;
    tick();
    check("flush_valid", 64'(cdb.valid), 64'd0);
    check("flush_gnt",   64'(gnt),       64'd0);
    check("flush_stall", 64'(stall),     64'd0);
    @(negedge clk);
    flush = 1'b0;
    tick();
    check("after_flush_ptr", 64'(gnt), 64'h10);
    @(negedge clk);
    req = '0;
    tick();

    // async reset mid-broadcast
    @(negedge clk);
    req = 5'b01100;
    tick();
    check("pre_rst_gnt", 64'(gnt), 64'h04);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check("rst_async_cdb",   64'(cdb),   64'd0);
    check("rst_async_gnt",   64'(gnt),   64'd0);
    check("rst_async_stall", 64'(stall), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    req = 5'b01100;
    tick();
    check("post_rst_lowest", 64'(gnt), 64'h04);

    // randomized traffic
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      flush = ($urandom_range(0, 19) == 0);
      for (int i = 0; i < N; i++) begin
        if (req[i]) begin
          if (gnt[i] && $urandom_range(0, 3) != 0) req[i] = 1'b0;
          else if ($urandom_range(0, 11) == 0) req[i] = 1'b0;
        end else if ($urandom_range(0, 2) == 0) begin
          set_fu(i, {3'(i), 5'($urandom)}, 32'($urandom));
          req[i] = 1'b1;
        end
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameter NUM_REQ, 5, number of functional-unit requesters (index 0 ALU, 1 JUMP, 2 LS, 3 MUL, 4 DIV).
REQ-002 Parameter STARVE_LIMIT, 4, wait cycles after which a pending requester gets forced priority; range 1..15.
REQ-003 clk  input  1  clock; all state updates on posedge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 flush  input  1  pipeline flush; synchronous, highest priority after rst.
REQ-006 req_i  input  NUM_REQ  per-FU broadcast request; held high until the FU sees its own tag valid on cdb_o.
REQ-007 data_i  input  NUM_REQ x tagged_data_t  per-FU tag and value; stable while the matching req_i is high.
REQ-008 cdb_o  output  cdb_bus_t  registered common data bus: valid, tag, data.
REQ-009 gnt_o  output  NUM_REQ  registered one-hot grant; identifies the source of the current cdb_o.
REQ-010 stall_o  output  NUM_REQ  registered; bit i high when req_i was high and not granted last cycle.

Function
REQ-011 One winner per cycle; the winner's tag/value appear on cdb_o one cycle after the arbitration edge (latency 1).
REQ-012 cdb_o.valid = 1 exactly when gnt_o is nonzero; gnt_o is either zero or one-hot.
REQ-013 Eligibility: req_i[i] high AND i not equal to the requester granted in the immediately preceding cycle; this prevents double broadcast while the FU retires its request.
REQ-014 Base policy: round-robin; search starts at index (last_winner+1) mod NUM_REQ and wraps; after reset the pointer selects index 0 first.
REQ-015 Starvation counter per requester, saturating at STARVE_LIMIT: +1 each cycle eligible and not granted; cleared when granted or when req_i is low.
REQ-016 If any eligible requester's counter equals STARVE_LIMIT, the lowest-index such requester wins, overriding round-robin.
REQ-017 The round-robin pointer updates to the winner index on every grant, forced or not; no grant leaves it unchanged.
REQ-018 No eligible requester: cdb_o.valid=0, gnt_o=0, cdb_o.tag=0, cdb_o.data holds its previous value.
REQ-019 Single eligible requester wins regardless of pointer position, including wrap from NUM_REQ-1 to 0.
REQ-020 flush: at the edge, cdb_o.valid, gnt_o and stall_o are cleared, all starvation counters are cleared, and the pointer is kept; requests sampled in the flush cycle are not granted.
REQ-021 A requester dropping req_i in the same cycle it would win is not granted; arbitration uses sampled req_i only.
REQ-022 tag on cdb_o is copied verbatim from data_i; the arbiter does not decode tag fields.

Reset
REQ-023 rst asserted: cdb_o all zero, gnt_o=0, stall_o=0, counters 0, pointer selects index 0, last-winner marker none; takes effect immediately, including mid-arbitration.
REQ-024 First arbitration is on the first posedge after rst deasserts.

Structure
REQ-025 tagged_data_t, cdb_bus_t, NUM_SRBITS and FU tag constants come from the shared package; NUM_REQ default and FU index constants are added there.
REQ-026 One sub-module, rr_pick: a combinational rotate-priority one-hot picker (request vector plus start index, returning a one-hot grant); it is instantiated once.
REQ-027 All outputs are driven from flops; no combinational path from req_i to cdb_o.

Verification
REQ-028 Single request req_i=5'b10000 with tag 0x84 and data 0x0000_0007 -> next cycle cdb_o={1,0x84,7}, gnt_o=5'b10000; held request not regranted in the following cycle.
REQ-029 All five requesting continuously with each FU dropping req one cycle after its grant -> grants 0,1,2,3,4 in order, no duplicates, stall_o reflects waiting FUs.
REQ-030 STARVE_LIMIT=2, FU0 and FU1 toggle requests so round-robin repeatedly skips FU3 -> FU3 granted no later than 3 cycles after its request.
REQ-031 flush asserted with 3 pending requests -> next cycle cdb_o.valid=0, gnt_o=0, counters 0; after flush, arbitration resumes from the retained pointer.
REQ-032 rst pulsed between clock edges during an active broadcast -> outputs zero immediately; first grant after release goes to the lowest-index requester.
